interrupt_ctrl: RTL

Interrupt entry sequencer for the 8-bit RISC core.
- Detects an external interrupt request and waits for an instruction boundary.
- Pushes PC and flags onto the stack in Data_Memory through the shared write port.
- Loads the ISR address from Data_Memory's interrupt_vector output (RAM[1], 0x3C after init).
- Holds the core stalled during entry and tracks in-ISR status until RTI.

---
 rtl/interrupt_ctrl_pkg.sv | 25 ++
 rtl/interrupt_ctrl_if.sv | 39 +++
 rtl/interrupt_ctrl_int_sync.sv | 36 +++
 rtl/interrupt_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
package interrupt_ctrl_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;

    // Data_Memory locations of the reset and interrupt vectors
    localparam logic [ADDR_W-1:0] RESET_VEC_ADDR = 8'h00;
    localparam logic [ADDR_W-1:0] VEC_ADDR       = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PUSH_PC    = 3'd1,
        ST_PUSH_FLAGS = 3'd2,
        ST_VECTOR     = 3'd3,
        ST_ISR        = 3'd4
    } state_t;

    // Stack grows down; addresses wrap modulo 256
    function automatic logic [ADDR_W-1:0] stack_dec(input logic [ADDR_W-1:0] sp,
                                                    input logic [1:0] n);
        return sp - ADDR_W'(n);
    endfunction

endpackage

// File: rtl/interrupt_ctrl_if.sv
// Core/memory side signals of the interrupt sequencer.
// master: the sequencer; slave: core and Data_Memory.
interface interrupt_ctrl_if #(
    parameter int unsigned FLAG_W = 4
);
    import interrupt_ctrl_pkg::*;

    logic              int_en;
    logic              instr_boundary;
    logic              rti;
    logic [ADDR_W-1:0] pc_in;
    logic [FLAG_W-1:0] flags_in;
    logic [ADDR_W-1:0] sp_in;
    logic [ADDR_W-1:0] interrupt_vector;

    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              sp_load;
    logic [ADDR_W-1:0] sp_new;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_new;
    logic              stall;
    logic              in_isr;
    logic              pending;

    modport master (
        input  int_en, instr_boundary, rti, pc_in, flags_in, sp_in, interrupt_vector,
        output mem_write, mem_addr, mem_wdata, sp_load, sp_new, pc_load, pc_new,
               stall, in_isr, pending
    );

    modport slave (
        output int_en, instr_boundary, rti, pc_in, flags_in, sp_in, interrupt_vector,
        input  mem_write, mem_addr, mem_wdata, sp_load, sp_new, pc_load, pc_new,
               stall, in_isr, pending
    );

endinterface

// File: rtl/interrupt_ctrl_int_sync.sv
// Synchroniser chain for the asynchronous interrupt line plus rising-edge detect.
module interrupt_ctrl_int_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   prev_q;
    logic                   prev_vld_q;

    // Shift the line through the chain; vld_q marks stages holding a post-reset sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q     <= '0;
            vld_q      <= '0;
            prev_q     <= 1'b0;
            prev_vld_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
            vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q     <= sync_q[SYNC_STAGES-1];
            prev_vld_q <= vld_q[SYNC_STAGES-1];
        end
    end

    // A line already high when reset releases is a level, not an edge: the
    // cleared flops would otherwise fake a 0->1 transition, so an edge needs
    // the previous sample to be a real one.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & prev_vld_q;

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt entry sequencer: stacks PC and flags, vectors to the ISR, tracks in-ISR.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FLAG_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                intr_in,
    interrupt_ctrl_if.master    bus
);

    state_t            state;
    logic              pending_q;
    logic [FLAG_W-1:0] flags_latch;
    logic [ADDR_W-1:0] sp_latch;
    logic              rise;
    logic              accept;

    interrupt_ctrl_int_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(intr_in),
        .rise    (rise)
    );

    assign accept = (state == ST_IDLE) & pending_q & bus.int_en & bus.instr_boundary;

    // Sequencer with outputs registered from the state being entered.
    // The PC needs no separate latch: the PUSH_PC write data register holds it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            pending_q     <= 1'b0;
            flags_latch   <= '0;
            sp_latch      <= '0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.sp_load   <= 1'b0;
            bus.sp_new    <= '0;
            bus.pc_load   <= 1'b0;
            bus.stall     <= 1'b0;
            bus.in_isr    <= 1'b0;
        end else begin
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.sp_load   <= 1'b0;
            bus.sp_new    <= '0;
            bus.pc_load   <= 1'b0;
            bus.stall     <= 1'b0;
            bus.in_isr    <= 1'b0;

            // a new edge wins over the clear on the acceptance cycle
            if (rise) begin
                pending_q <= 1'b1;
            end else if (accept) begin
                pending_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        flags_latch   <= bus.flags_in;
                        sp_latch      <= bus.sp_in;
                        state         <= ST_PUSH_PC;
                        bus.mem_write <= 1'b1;
                        bus.mem_addr  <= bus.sp_in;
                        bus.mem_wdata <= bus.pc_in;
                        bus.stall     <= 1'b1;
                    end
                end
                ST_PUSH_PC: begin
                    state         <= ST_PUSH_FLAGS;
                    bus.mem_write <= 1'b1;
                    bus.mem_addr  <= stack_dec(sp_latch, 2'd1);
                    bus.mem_wdata <= DATA_W'(flags_latch);
                    bus.stall     <= 1'b1;
                end
                ST_PUSH_FLAGS: begin
                    state       <= ST_VECTOR;
                    bus.pc_load <= 1'b1;
                    bus.sp_load <= 1'b1;
                    bus.sp_new  <= stack_dec(sp_latch, 2'd2);
                    bus.stall   <= 1'b1;
                end
                ST_VECTOR: begin
                    state      <= ST_ISR;
                    bus.in_isr <= 1'b1;
                end
                ST_ISR: begin
                    if (bus.rti) begin
                        state <= ST_IDLE;
                    end else begin
                        bus.in_isr <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The vector is taken from memory during the VECTOR cycle itself
    assign bus.pc_new  = bus.pc_load ? bus.interrupt_vector : '0;
    assign bus.pending = pending_q;

endmodule
